// File: rtl/ysyx_22050612_wb_arbiter_if.sv
// Write-back arbiter bus: ALU/LSU offer channels,
// registered register-file write port, forwarding and commit count.
interface ysyx_22050612_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  fwd_valid;
    logic [ADDR_WIDTH-1:0] fwd_rd;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [31:0]           commit_cnt;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        input  fwd_valid, fwd_rd, fwd_data,
        input  commit_cnt
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata,
        output fwd_valid, fwd_rd, fwd_data,
        output commit_cnt
    );
endinterface

// File: rtl/ysyx_22050612_wb_arbiter.sv
// ALU/LSU write-back arbiter: LSU-priority grant with ALU
// anti-starvation, one registered RF write per cycle.
module ysyx_22050612_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int STARVE_MAX = 3
) (
    input logic clk,
    input logic rst_n,
    ysyx_22050612_wb_arbiter_if.slave bus
);
    localparam logic [2:0] SMAX = 3'(STARVE_MAX);

    logic [2:0]            starve_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [31:0]           commit_q;

    logic                  force_alu;
    logic                  alu_xfer;
    logic                  lsu_xfer;
    logic [ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;

    // Grant: LSU normally wins, a starved ALU is forced through.
    always_comb begin
        force_alu  = (starve_q == SMAX) && bus.alu_valid;
        lsu_xfer   = rst_n && bus.lsu_valid && !force_alu;
        alu_xfer   = rst_n && bus.alu_valid
                     && (!bus.lsu_valid || force_alu);
        grant_rd   = alu_xfer ? bus.alu_rd : bus.lsu_rd;
        grant_data = alu_xfer ? bus.alu_data : bus.lsu_data;
    end

    assign bus.alu_ready  = alu_xfer;
    assign bus.lsu_ready  = lsu_xfer;
    assign bus.rf_wen     = wen_q;
    assign bus.rf_waddr   = waddr_q;
    assign bus.rf_wdata   = wdata_q;
    assign bus.fwd_valid  = wen_q;
    assign bus.fwd_rd     = waddr_q;
    assign bus.fwd_data   = wdata_q;
    assign bus.commit_cnt = commit_q;

    // Count consecutive ALU losses, saturating at the force threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 3'd0;
        end else if (!bus.alu_valid || alu_xfer) begin
            starve_q <= 3'd0;
        end else if (lsu_xfer && starve_q != SMAX) begin
            starve_q <= starve_q + 3'd1;
        end
    end

    // Stage the granted result; x0 writes never raise the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (alu_xfer || lsu_xfer) begin
            wen_q   <= (grant_rd != '0);
            waddr_q <= grant_rd;
            wdata_q <= grant_data;
        end else begin
            wen_q   <= 1'b0;
        end
    end

    // Commit counter: one per accepted result, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_q <= 32'd0;
        end else if (alu_xfer || lsu_xfer) begin
            commit_q <= commit_q + 32'd1;
        end
    end
endmodule

// File: tb/tb_ysyx_22050612_wb_arbiter.sv
// Directed bench for the write-back arbiter.
// Inputs change on negedge; checks run away from posedge.
module tb_ysyx_22050612_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ysyx_22050612_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) bus ();

    ysyx_22050612_wb_arbiter #(
        .ADDR_WIDTH(5), .DATA_WIDTH(64), .STARVE_MAX(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard,
                         input logic [63:0] ad, input logic lv,
                         input logic [4:0] lrd, input logic [63:0] ld);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ld;
    endtask

    task automatic chk_rf(input string tag, input logic wen,
                          input logic [4:0] a, input logic [63:0] d,
                          input logic [31:0] cnt);
        chk({tag, "_wen"}, 64'(bus.rf_wen), 64'(wen));
        chk({tag, "_waddr"}, 64'(bus.rf_waddr), 64'(a));
        chk({tag, "_wdata"}, bus.rf_wdata, d);
        chk({tag, "_fwdv"}, 64'(bus.fwd_valid), 64'(wen));
        chk({tag, "_fwdrd"}, 64'(bus.fwd_rd), 64'(a));
        chk({tag, "_fwdd"}, bus.fwd_data, d);
        chk({tag, "_cnt"}, 64'(bus.commit_cnt), 64'(cnt));
    endtask

    task automatic chk_rdy(input string tag, input logic ar,
                           input logic lr);
        chk({tag, "_ardy"}, 64'(bus.alu_ready), 64'(ar));
        chk({tag, "_lrdy"}, 64'(bus.lsu_ready), 64'(lr));
    endtask

    logic       exp_l;
    logic [4:0] exp_a;
    logic [31:0] cnt;

    initial begin
        drive(1'b1, 5'd9, 64'h99, 1'b1, 5'd8, 64'h88);
        #12;
        chk_rdy("rst", 1'b0, 1'b0);
        chk_rf("rst", 1'b0, 5'd0, 64'h0, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0);
        #1 chk_rdy("alu1", 1'b1, 1'b0);
        @(posedge clk); #1;
        chk_rf("alu1", 1'b1, 5'd5, 64'h1234, 32'd1);

        @(negedge clk);
        drive(1'b1, 5'd1, 64'hA, 1'b1, 5'd2, 64'hB);
        #1 chk_rdy("both", 1'b0, 1'b1);
        @(posedge clk); #1;
        chk_rf("both_lsu", 1'b1, 5'd2, 64'hB, 32'd2);
        @(negedge clk);
        drive(1'b1, 5'd1, 64'hA, 1'b0, 5'd0, 64'h0);
        #1 chk_rdy("both2", 1'b1, 1'b0);
        @(posedge clk); #1;
        chk_rf("both_alu", 1'b1, 5'd1, 64'hA, 32'd3);

        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        #1 chk_rdy("idle", 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_rf("idle", 1'b0, 5'd1, 64'hA, 32'd3);

        cnt = 32'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1'b1, 5'd7, 64'h7, 1'b1, 5'(10 + i), 64'(100 + i));
            exp_l = !(i == 3 || i == 7);
            #1 chk_rdy($sformatf("stv%0d", i), !exp_l, exp_l);
            @(posedge clk); #1;
            cnt++;
            exp_a = exp_l ? 5'(10 + i) : 5'd7;
            chk_rf($sformatf("stv%0d", i), 1'b1, exp_a,
                   exp_l ? 64'(100 + i) : 64'h7, cnt);
        end

        @(negedge clk);
        drive(1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 64'h0);
        #1 chk_rdy("x0", 1'b1, 1'b0);
        @(posedge clk); #1;
        chk_rf("x0", 1'b0, 5'd0, 64'hFFFF, 32'd12);

        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        force dut.commit_q = 32'hFFFF_FFFF;
        #1 release dut.commit_q;
        chk("wrap_pre", 64'(bus.commit_cnt), 64'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 64'h33);
        @(posedge clk); #1;
        chk_rf("wrap", 1'b1, 5'd3, 64'h33, 32'd0);

        @(negedge clk);
        drive(1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'h0);
        @(posedge clk); #1;
        chk_rf("stage", 1'b1, 5'd4, 64'h44, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_rf("midrst", 1'b0, 5'd0, 64'h0, 32'd0);
        chk_rdy("midrst", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_22050612_wb_arbiter.md
Name: ysyx_22050612_wb_arbiter

Overview:
- Writer-side front end for the core's register-file write port.
- Accepts results from the ALU and the LSU over valid/ready, arbitrates between them, and drives one registered write per cycle (`rf_wen`/`rf_waddr`/`rf_wdata`).
- Exports forwarding info so operand readers see the in-flight write before it lands in the array, plus a commit counter for difftest/perf.
- Sits between the execute/memory stages and the register file.

Parameters:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 64, register data width.
- STARVE_MAX, 3, consecutive ALU losses after which the ALU is forced to win (range 1..7).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- lsu_valid  in  1  LSU load result offered.
- lsu_ready  out  1  LSU result accepted this cycle.
- lsu_rd  in  ADDR_WIDTH  LSU destination register.
- lsu_data  in  DATA_WIDTH  LSU result.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  write address (registered).
- rf_wdata  out  DATA_WIDTH  write data (registered).
- fwd_valid  out  1  equals `rf_wen`; the write lands at the next posedge.
- fwd_rd  out  ADDR_WIDTH  equals `rf_waddr`.
- fwd_data  out  DATA_WIDTH  equals `rf_wdata`.
- commit_cnt  out  32  count of accepted results, including rd=0.

Behaviour:
- Reset (rst_n=0, async):
  - `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `commit_cnt`=0, starve counter=0.
  - `alu_ready`=`lsu_ready`=0 while rst_n=0.
- Grant is combinational each cycle:
  - `force_alu` = (starve counter == STARVE_MAX) && `alu_valid`.
  - `lsu_ready` = `lsu_valid` && !`force_alu`.
  - `alu_ready` = `alu_valid` && (!`lsu_valid` || `force_alu`).
  - At most one ready is high per cycle. A ready is never high without its valid.
- Handshake:
  - Transfer occurs when valid && ready.
  - Sources must hold valid/rd/data stable until the transfer.
  - No ready depends on `rf_*` state; the block never back-pressures for any reason other than losing arbitration.
- Write stage, 1-cycle latency. On the posedge after a transfer:
  - `rf_waddr` <= granted rd.
  - `rf_wdata` <= granted data.
  - `rf_wen` <= (granted rd != 0).
- With no transfer, `rf_wen` <= 0. `rf_waddr`/`rf_wdata` hold their previous values.
- x0 rule: a transfer with rd=0 completes the handshake and increments `commit_cnt`, but never asserts `rf_wen`.
- Starve counter (3 bits, saturating at STARVE_MAX):
  - Increments when `alu_valid` && `lsu_valid` && the LSU wins.
  - Clears when the ALU transfers, or when `alu_valid`=0.
  - Holds otherwise.
  - After forcing, the next simultaneous request goes to the LSU again.
- `commit_cnt`: +1 per transfer, wraps at 2^32 (0xFFFFFFFF -> 0).
- Forwarding: the `fwd_*` outputs are wires equal to the `rf_*` outputs. Consumers reading the register file combinationally must take `fwd_data` when `fwd_valid` && `fwd_rd`==rs && rs!=0.
- Back-to-back transfers are legal every cycle; throughput is 1 write/cycle.
- Reset asserted mid-stream:
  - Any pending (unaccepted) offer is dropped from the block's view.
  - A write staged in `rf_*` is cancelled; `rf_wen` falls to 0 immediately (async).

Test Plan:
- Reset -> all outputs 0. Release rst_n, drive `alu_valid`=1, rd=5, data=0x1234 for 1 cycle -> `alu_ready`=1 that cycle; next cycle `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `fwd_*` identical; `commit_cnt`=1.
- Simultaneous `alu_valid`/`lsu_valid` (ALU rd=1, data=0xA; LSU rd=2, data=0xB) -> LSU granted first, `rf_waddr`=2, data 0xB; ALU granted next cycle, `rf_waddr`=1, data 0xA.
- LSU valid continuously with a new rd each cycle, ALU valid continuously, STARVE_MAX=3 -> ALU loses 3 times, wins on the 4th cycle, then loses 3 more; `lsu_ready` is low exactly on the forced cycles.
- ALU transfer with rd=0, data=0xFFFF -> handshake completes, `rf_wen` stays 0, `commit_cnt` increments by 1.
- Preload `commit_cnt`=0xFFFFFFFF via 2^32-1 transfers (or force), then 1 more transfer -> `commit_cnt`=0.
- Stage a write (`rf_wen`=1), assert rst_n=0 mid-cycle -> `rf_wen` goes 0 immediately without waiting for clk; `commit_cnt`=0.
